jt51_exp_pipe: RTL and testbench
================================

Name: jt51_exp_pipe

Overview:
- Parametrised log-to-linear converter for the operator output path.
- Converts an attenuation word of integer and fraction parts into a signed linear sample through a 3-stage, clock-enabled pipeline.
- Stages: exp-table lookup, exponent shift, sign application.
- Generalises the fixed 32-entry exponent ROM: configurable table resolution, mantissa width and output format, plus channel-tag pass-through and bubble tracking.

Parameters:
- FW, 8: fraction bits of attenuation; table depth 2^FW.
- SW, 4: integer (shift) bits of attenuation.
- MW, 10: mantissa fraction bits; table entries are MW+1 bits wide.
- CHW, 5: channel/slot tag width.
- TWOS, 1: 1 = two's-complement output; 0 = sign-magnitude output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  clock enable; pipeline advances only when 1
- in_valid  in  1  input sample present
- atten  in  SW+FW  attenuation {int, frac}; larger = quieter
- sign  in  1  sample sign (1 = negative)
- ch_in  in  CHW  channel tag
- out_valid  out  1  out_data/ch_out hold a new result
- out_data  out  MW+2  linear sample
- ch_out  out  CHW  tag matching out_data

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset: all pipeline valid bits, data and tag registers clear to 0; out_valid=0, out_data=0, ch_out=0. Reset mid-stream discards all in-flight samples. The first result after release appears no earlier than 3 cen cycles after the first accepted input.
- Table contents: entry k (0..2^FW-1) = floor(2^MW * 2^((2^FW-1-k)/2^FW) + 0.5), MW+1 bits.
  - Hidden bit is always 1, so entries lie in [2^MW, 2^(MW+1)).
  - Defaults: k=0 -> 2042; k=255 -> 1024.
  - The table is built at elaboration from a constant function (integer arithmetic or real-to-integer in initial) and must be synthesisable as ROM.
- Stage 1, on cen:
  - v1 <= in_valid.
  - If in_valid: m1 <= table[atten[FW-1:0]], e1 <= atten[SW+FW-1:FW], s1 <= sign, c1 <= ch_in.
- Stage 2, on cen:
  - v2 <= v1.
  - If v1: mag2 <= m1 >> e1 (logical). Shifts >= MW+1 give 0; no wrap, no error.
  - s2 <= s1 & (mag2_next != 0), i.e. negative zero is forced to +0. c2 <= c1.
- Stage 3, on cen:
  - out_valid <= v2.
  - If v2: ch_out <= c2, and out_data is:
    - TWOS=1: s2 ? -{1'b0,mag2} : {1'b0,mag2}, MW+2 bits.
    - TWOS=0: {s2, mag2}.
- Latency: exactly 3 cen-qualified cycles from the input sample to out_valid.
- Throughput: one sample per cen cycle; no backpressure.
- Bubbles: in_valid=0 propagates as a 0 valid bit. Data/tag registers of a stage hold their previous value when that stage's incoming valid is 0, so out_data/ch_out keep the last result while out_valid=0.
- cen=0: every register, including out_valid, holds. No sample is lost or duplicated across any length of stall.
- cen=1 with simultaneous input and output: both occur in the same edge (full pipelining).
- Arithmetic width:
  - Magnitude ≤ 2^(MW+1)-1, so MW+2 bits hold ±magnitude without overflow.
  - Most negative output (TWOS=1, defaults) = -2042 = 12'h806.
- No combinational path from inputs to outputs.

Test Plan:
- Table endpoints: defaults, cen=1, in_valid=1, sign=0.
  - atten=12'h000 -> out_data=2042 with out_valid on the 3rd edge.
  - atten=12'h0FF -> 1024.
  - atten=12'h1FF -> 512.
- Large shift: atten={4'd11,8'd0} -> 0; atten={4'd15,8'hFF} -> 0; both with out_valid=1.
- Sign handling:
  - TWOS=1, sign=1, atten=0 -> out_data=12'h806.
  - TWOS=0, same input -> 12'hFFA (sign bit plus 2042).
  - sign=1 with atten={4'd12,8'd0} -> 0 in both modes (no -0).
- Streaming: 32 back-to-back samples, ch_in=0..31, in_valid pulled low on every 4th.
  - Outputs arrive in order, ch_out matches each sample, gaps match the input gaps.
  - out_data holds its value during gaps.
- Stall: cen low for 5 cycles with 3 samples in flight.
  - Outputs frozen during the stall.
  - After cen returns, the 3 results emerge on consecutive cen edges with no loss or duplication.
- Reset: assert rst_n=0 asynchronously between edges with a full pipeline.
  - out_valid, out_data and ch_out go 0 immediately.
  - After release, no stale sample appears; the first new result comes 3 cen edges after the first new input.

Source files
------------

// File: rtl/jt51_exp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : jt51_exp_pipe
//  Description : Log-to-linear converter for the operator output path.
//                Three clock-enabled stages: exp-table lookup, exponent
//                shift, sign application. Carries a channel tag and a
//                valid bit alongside each sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt51_exp_pipe #(
  parameter int FW   = 8,
  parameter int SW   = 4,
  parameter int MW   = 10,
  parameter int CHW  = 5,
  parameter int TWOS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             in_valid,
  input  logic [SW+FW-1:0] atten,
  input  logic             sign,
  input  logic [CHW-1:0]   ch_in,
  output logic             out_valid,
  output logic [MW+1:0]    out_data,
  output logic [CHW-1:0]   ch_out
);

  localparam int C_DEPTH = 1 << FW;

  // Integer square root of a 128-bit value (result fits in 64 bits).
  function automatic logic [127:0] isqrt(input logic [127:0] x);
    logic [127:0] res;
    logic [127:0] t;
    res = '0;
    for (int b = 63; b >= 0; b--) begin
      t = res | (128'd1 << b);
      if (t * t <= x) res = t;
    end
    return res;
  endfunction

  // Table entry k = round(2^MW * 2^((2^FW-1-k)/2^FW)), evaluated in Q.60
  // fixed point: 2^(j/2^FW) is the product of repeated square roots of 2
  // selected by the bits of j.
  function automatic logic [MW:0] exp_entry(input int k);
    logic [127:0] acc;
    logic [127:0] r;
    logic [127:0] rnd;
    int           j;
    j   = C_DEPTH - 1 - k;
    acc = 128'd1 << 60;
    r   = 128'd1 << 61;
    for (int b = FW - 1; b >= 0; b--) begin
      r = isqrt(r << 60);
      if (((j >> b) & 1) == 1) acc = (acc * r) >> 60;
    end
    rnd = ((acc << MW) + (128'd1 << 59)) >> 60;
    return rnd[MW:0];
  endfunction

  // Exponent ROM, every entry folded to a constant at elaboration.
  logic [MW:0] w_rom [C_DEPTH];

  for (genvar k = 0; k < C_DEPTH; k++) begin : g_rom
    localparam logic [MW:0] C_VAL = exp_entry(k);
    assign w_rom[k] = C_VAL;
  end

  logic             v1_q, v1_d;
  logic [MW:0]      m1_q, m1_d;
  logic [SW-1:0]    e1_q, e1_d;
  logic             s1_q, s1_d;
  logic [CHW-1:0]   c1_q, c1_d;
  logic             v2_q, v2_d;
  logic [MW:0]      mag2_q, mag2_d;
  logic             s2_q, s2_d;
  logic [CHW-1:0]   c2_q, c2_d;
  logic             out_valid_q, out_valid_d;
  logic [MW+1:0]    out_data_q, out_data_d;
  logic [CHW-1:0]   ch_out_q, ch_out_d;

  // Stage 1: table lookup; data/tag registers only load on a valid input.
  always_comb begin
    v1_d = in_valid;
    m1_d = m1_q;
    e1_d = e1_q;
    s1_d = s1_q;
    c1_d = c1_q;
    if (in_valid) begin
      m1_d = w_rom[atten[FW-1:0]];
      e1_d = atten[SW+FW-1:FW];
      s1_d = sign;
      c1_d = ch_in;
    end
  end

  // Stage 2: exponent shift; a zero magnitude never carries a negative sign.
  always_comb begin
    v2_d   = v1_q;
    mag2_d = mag2_q;
    s2_d   = s2_q;
    c2_d   = c2_q;
    if (v1_q) begin
      mag2_d = m1_q >> e1_q;
      s2_d   = s1_q & (mag2_d != '0);
      c2_d   = c1_q;
    end
  end

  // Stage 3: sign application in the selected output format.
  always_comb begin
    out_valid_d = v2_q;
    out_data_d  = out_data_q;
    ch_out_d    = ch_out_q;
    if (v2_q) begin
      ch_out_d = c2_q;
      if (TWOS != 0) begin
        out_data_d = s2_q ? -{1'b0, mag2_q} : {1'b0, mag2_q};
      end else begin
        out_data_d = {s2_q, mag2_q};
      end
    end
  end

  // Pipeline registers: advance together on cen, clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      m1_q        <= '0;
      e1_q        <= '0;
      s1_q        <= 1'b0;
      c1_q        <= '0;
      v2_q        <= 1'b0;
      mag2_q      <= '0;
      s2_q        <= 1'b0;
      c2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ch_out_q    <= '0;
    end else if (cen) begin
      v1_q        <= v1_d;
      m1_q        <= m1_d;
      e1_q        <= e1_d;
      s1_q        <= s1_d;
      c1_q        <= c1_d;
      v2_q        <= v2_d;
      mag2_q      <= mag2_d;
      s2_q        <= s2_d;
      c2_q        <= c2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ch_out_q    <= ch_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ch_out    = ch_out_q;

endmodule
`default_nettype wire

// File: tb/tb_jt51_exp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt51_exp_pipe
//  Description : Bench for jt51_exp_pipe: both output formats side by side,
//                compared every cycle against a real-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt51_exp_pipe;

  localparam int FW  = 8;
  localparam int SW  = 4;
  localparam int MW  = 10;
  localparam int CHW = 5;
  localparam int N   = 1 << FW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b0;
  logic             in_valid = 1'b0;
  logic [SW+FW-1:0] atten = '0;
  logic             sign = 1'b0;
  logic [CHW-1:0]   ch_in = '0;

  logic             out_valid_t, out_valid_s;
  logic [MW+1:0]    out_data_t, out_data_s;
  logic [CHW-1:0]   ch_out_t, ch_out_s;

  jt51_exp_pipe #(.FW(FW), .SW(SW), .MW(MW), .CHW(CHW), .TWOS(1)) u_dut_twos (
    .clk(clk), .rst_n(rst_n), .cen(cen), .in_valid(in_valid), .atten(atten),
    .sign(sign), .ch_in(ch_in), .out_valid(out_valid_t), .out_data(out_data_t),
    .ch_out(ch_out_t)
  );

  jt51_exp_pipe #(.FW(FW), .SW(SW), .MW(MW), .CHW(CHW), .TWOS(0)) u_dut_sm (
    .clk(clk), .rst_n(rst_n), .cen(cen), .in_valid(in_valid), .atten(atten),
    .sign(sign), .ch_in(ch_in), .out_valid(out_valid_s), .out_data(out_data_s),
    .ch_out(ch_out_s)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int tbl [N];

  typedef struct {
    logic             v;
    logic [SW+FW-1:0] a;
    logic             s;
    logic [CHW-1:0]   c;
  } rec_t;

  rec_t           hist [2];
  logic           exp_v;
  logic [MW+1:0]  exp_t, exp_s;
  logic [CHW-1:0] exp_c;

  // Linear value from the table formula, shift and sign rules.
  function automatic logic [MW+1:0] model_out(input logic [SW+FW-1:0] a,
                                              input logic s, input logic twos);
    int   mag;
    int   e;
    logic neg;
    e   = int'(a[SW+FW-1:FW]);
    mag = (e >= MW + 1) ? 0 : (tbl[a[FW-1:0]] >> e);
    neg = s && (mag != 0);
    if (twos) return neg ? (MW+2)'(-mag) : (MW+2)'(mag);
    return {neg, (MW+1)'(mag)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: an accepted sample shows up two cen edges after acceptance;
  // a bubble leaves the last result in place with the valid flag low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] <= '{1'b0, '0, 1'b0, '0};
      hist[1] <= '{1'b0, '0, 1'b0, '0};
      exp_v   <= 1'b0;
      exp_t   <= '0;
      exp_s   <= '0;
      exp_c   <= '0;
    end else if (cen) begin
      hist[0] <= '{in_valid, atten, sign, ch_in};
      hist[1] <= hist[0];
      exp_v   <= hist[1].v;
      if (hist[1].v) begin
        exp_t <= model_out(hist[1].a, hist[1].s, 1'b1);
        exp_s <= model_out(hist[1].a, hist[1].s, 1'b0);
        exp_c <= hist[1].c;
      end
    end
  end

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    chk("valid_twos", 32'(out_valid_t), 32'(exp_v));
    chk("data_twos",  32'(out_data_t),  32'(exp_t));
    chk("ch_twos",    32'(ch_out_t),    32'(exp_c));
    chk("valid_sm",   32'(out_valid_s), 32'(exp_v));
    chk("data_sm",    32'(out_data_s),  32'(exp_s));
    chk("ch_sm",      32'(ch_out_s),    32'(exp_c));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample, checked against hand-computed values on the 3rd edge.
  task automatic send_lit(input string name, input logic [SW+FW-1:0] a, input logic s,
                          input logic [MW+1:0] lit_t, input logic [MW+1:0] lit_s);
    cen      = 1'b1;
    in_valid = 1'b1;
    atten    = a;
    sign     = s;
    ch_in    = CHW'($urandom);
    step();
    in_valid = 1'b0;
    step();
    chk({name, "_early"}, 32'(out_valid_t), 32'd0);
    step();
    chk({name, "_vt"}, 32'(out_valid_t), 32'd1);
    chk({name, "_vs"}, 32'(out_valid_s), 32'd1);
    chk({name, "_dt"}, 32'(out_data_t),  32'(lit_t));
    chk({name, "_ds"}, 32'(out_data_s),  32'(lit_s));
  endtask

  initial begin
    for (int k = 0; k < N; k++)
      tbl[k] = int'($floor((2.0 ** MW) * (2.0 ** (real'(N - 1 - k) / real'(N))) + 0.5));

    // Reset state
    rst_n = 1'b0;
    cen   = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid_t), 32'd0);
    chk("rst_data",  32'(out_data_t),  32'd0);
    chk("rst_ch",    32'(ch_out_t),    32'd0);
    rst_n = 1'b1;
    step();

    // Table endpoints, large shifts, sign handling
    send_lit("a000",  12'h000, 1'b0, 12'd2042, 12'd2042);
    send_lit("a0ff",  12'h0FF, 1'b0, 12'd1024, 12'd1024);
    send_lit("a1ff",  12'h1FF, 1'b0, 12'd512,  12'd512);
    send_lit("sh11",  {4'd11, 8'd0}, 1'b0, 12'd0, 12'd0);
    send_lit("shff",  12'hFFF, 1'b0, 12'd0, 12'd0);
    send_lit("neg0",  12'h000, 1'b1, 12'h806, 12'hFFA);
    send_lit("negz",  {4'd12, 8'd0}, 1'b1, 12'd0, 12'd0);

    // Streaming with a bubble on every 4th slot
    for (int i = 0; i < 32; i++) begin
      in_valid = (i % 4) != 3;
      atten    = (SW+FW)'($urandom);
      sign     = 1'($urandom);
      ch_in    = CHW'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Stall with samples in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      atten    = (SW+FW)'($urandom);
      sign     = 1'($urandom);
      ch_in    = CHW'(i + 5);
      step();
    end
    cen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      atten = (SW+FW)'($urandom);
      step();
    end
    cen      = 1'b1;
    in_valid = 1'b0;
    repeat (4) step();

    // Randomised traffic with random clock enable
    for (int i = 0; i < 600; i++) begin
      cen      = $urandom_range(0, 3) != 0;
      in_valid = $urandom_range(0, 4) != 0;
      atten    = (SW+FW)'($urandom);
      if ($urandom_range(0, 7) == 0) atten[SW+FW-1:FW] = SW'($urandom_range(10, 15));
      sign     = 1'($urandom);
      ch_in    = CHW'($urandom);
      step();
    end
    cen      = 1'b1;
    in_valid = 1'b0;
    repeat (3) step();

    // Asynchronous reset with a full pipeline
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      atten    = (SW+FW)'($urandom_range(0, 511));
      sign     = 1'($urandom);
      ch_in    = CHW'($urandom_range(1, 31));
      step();
    end
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_vt", 32'(out_valid_t), 32'd0);
    chk("arst_dt", 32'(out_data_t),  32'd0);
    chk("arst_ct", 32'(ch_out_t),    32'd0);
    chk("arst_vs", 32'(out_valid_s), 32'd0);
    chk("arst_ds", 32'(out_data_s),  32'd0);
    chk("arst_cs", 32'(ch_out_s),    32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("no_stale", 32'(out_valid_t), 32'd0);
    send_lit("post_rst", 12'h0FF, 1'b1, 12'hC00, 12'hC00);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
